// File: rtl/l1_cache_tag_plru_pkg.sv
// l1_cache_tag_plru_pkg: shared geometry and flush FSM encoding for the L1 tag store
package l1_cache_tag_plru_pkg;
    localparam int L1_NUM_WAYS        = 4;
    localparam int L1_NUM_SETS        = 64;
    localparam int L1_TAG_WIDTH       = 20;
    localparam int L1_SET_INDEX_WIDTH = $clog2(L1_NUM_SETS);
    localparam int L1_WAY_INDEX_WIDTH = $clog2(L1_NUM_WAYS);
    typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} flush_state_e;
endpackage

// File: rtl/l1_cache_tag_plru_plru_tree.sv
// cache_plru_tree: tree pseudo-LRU touch and LRU-way walk for one set
module cache_plru_tree #(
    parameter int NUM_WAYS = 4,
    localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] plru_i,
    input  logic [WAY_BITS-1:0] way_i,
    output logic [NUM_WAYS-2:0] plru_o,
    output logic [WAY_BITS-1:0] lru_way_o
);
    // Heap-ordered nodes: touch points every node on way_i's path away from it, LRU follows the pointers
    always_comb begin
        int tn;
        int ln;
        plru_o    = plru_i;
        lru_way_o = '0;
        tn = 0;
        ln = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            plru_o[tn] = ~way_i[WAY_BITS-1-l];
            tn = 2 * tn + 1 + int'(way_i[WAY_BITS-1-l]);
            lru_way_o[WAY_BITS-1-l] = plru_i[ln];
            ln = 2 * ln + 1 + int'(plru_i[ln]);
        end
    end
endmodule

// File: rtl/l1_cache_tag_plru.sv
// l1_cache_tag_plru: N-way L1 tag/valid store with per-set tree PLRU and sequenced flush
module l1_cache_tag_plru
    import l1_cache_tag_plru_pkg::*;
#(
    parameter int NUM_WAYS   = L1_NUM_WAYS,
    parameter int NUM_SETS   = L1_NUM_SETS,
    parameter int TAG_WIDTH  = L1_TAG_WIDTH,
    parameter int ADDR_WIDTH = L1_TAG_WIDTH + L1_SET_INDEX_WIDTH,
    localparam int SET_BITS  = $clog2(NUM_SETS),
    localparam int WAY_BITS  = $clog2(NUM_WAYS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] request_addr,
    input  logic                  access_i,
    output logic                  cache_hit_o,
    output logic [WAY_BITS-1:0]   hit_way_o,
    output logic [NUM_WAYS-1:0]   hit_way_oh_o,
    output logic [WAY_BITS-1:0]   victim_way_o,
    input  logic                  update_i,
    input  logic                  invalidate_one_way,
    input  logic [WAY_BITS-1:0]   update_way_i,
    input  logic [TAG_WIDTH-1:0]  update_tag_i,
    input  logic [SET_BITS-1:0]   update_set_i,
    input  logic                  flush_i,
    output logic                  flush_busy_o
);
    flush_state_e           state_q, state_d;
    logic [SET_BITS-1:0]    flush_cnt_q, flush_cnt_d;
    logic                   acc_q, acc_d;
    logic [SET_BITS-1:0]    req_set_q, req_set_d;
    logic [TAG_WIDTH-1:0]   req_tag_q, req_tag_d;
    logic [NUM_WAYS-1:0]    valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]    valid_d [NUM_SETS];
    logic [NUM_WAYS-2:0]    plru_q [NUM_SETS];
    logic [NUM_WAYS-2:0]    plru_d [NUM_SETS];
    logic [TAG_WIDTH-1:0]   tag_mem [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]    hit_raw;
    logic [NUM_WAYS-1:0]    set_valid;
    logic [NUM_WAYS-2:0]    hit_plru, fill_base, fill_plru, unused_victim_plru;
    logic [WAY_BITS-1:0]    plru_victim, first_inv, unused_hit_lru, unused_fill_lru;

    // Tag storage has no reset; only valid bits decide whether an entry counts
    always_ff @(posedge clk) begin
        if (update_i) tag_mem[update_set_i][update_way_i] <= update_tag_i;
    end

    // Lookup latch, valid/PLRU arrays and flush FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            acc_q       <= 1'b0;
            req_set_q   <= '0;
            req_tag_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            acc_q       <= acc_d;
            req_set_q   <= req_set_d;
            req_tag_q   <= req_tag_d;
            valid_q     <= valid_d;
            plru_q      <= plru_d;
        end
    end

    // Request capture and flush sequencing; flush_i is only honoured from IDLE
    always_comb begin
        acc_d       = access_i;
        req_set_d   = request_addr[SET_BITS-1:0];
        req_tag_d   = request_addr[ADDR_WIDTH-1:SET_BITS];
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_IDLE && flush_i) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
        end else if (state_q == ST_FLUSH) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
            state_d     = (flush_cnt_q == SET_BITS'(NUM_SETS - 1)) ? ST_IDLE : ST_FLUSH;
        end
    end

    // Hit detection reads the arrays after the previous edge, so same-cycle writes are forwarded
    always_comb begin
        set_valid = valid_q[req_set_q];
        hit_raw   = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            hit_raw[w] = set_valid[w] && (tag_mem[req_set_q][w] == req_tag_q);
        hit_way_oh_o = (acc_q && state_q == ST_IDLE) ? hit_raw : '0;
        cache_hit_o  = |hit_way_oh_o;
        hit_way_o    = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (hit_way_oh_o[w]) hit_way_o = hit_way_o | WAY_BITS'(w);
        first_inv = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!set_valid[w]) first_inv = WAY_BITS'(w);
        victim_way_o = !acc_q ? '0 : (&set_valid) ? plru_victim : first_inv;
        flush_busy_o = (state_q == ST_FLUSH);
    end

    // Fill touch stacks on the hit touch when both hit the same set
    always_comb begin
        fill_base = (cache_hit_o && update_set_i == req_set_q) ? hit_plru : plru_q[update_set_i];
    end

    // Array updates: hit touch, fill/invalidate, then the sweep clears its set last
    always_comb begin
        valid_d = valid_q;
        plru_d  = plru_q;
        if (cache_hit_o) plru_d[req_set_q] = hit_plru;
        if (update_i) begin
            valid_d[update_set_i][update_way_i] = 1'b1;
            plru_d[update_set_i] = fill_plru;
        end
        if (invalidate_one_way) valid_d[update_set_i][update_way_i] = 1'b0;
        if (state_q == ST_FLUSH) begin
            valid_d[flush_cnt_q] = '0;
            plru_d[flush_cnt_q]  = '0;
        end
    end

    cache_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_hit_tree (
        .plru_i(plru_q[req_set_q]), .way_i(hit_way_o),
        .plru_o(hit_plru), .lru_way_o(unused_hit_lru)
    );

    cache_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_fill_tree (
        .plru_i(fill_base), .way_i(update_way_i),
        .plru_o(fill_plru), .lru_way_o(unused_fill_lru)
    );

    cache_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_victim_tree (
        .plru_i(plru_q[req_set_q]), .way_i('0),
        .plru_o(unused_victim_plru), .lru_way_o(plru_victim)
    );

    a_excl_update: assert property (@(posedge clk) disable iff (reset) !(update_i && invalidate_one_way));
    a_single_hit: assert property (@(posedge clk) disable iff (reset) acc_q |-> $onehot0(hit_raw));
endmodule

// File: doc/l1_cache_tag_plru.md
Name: l1_cache_tag_plru

Overview:
Parametrised L1 tag/valid store, the next generation of the 4-way L1 tag block. It has N ways, configurable sets and tag width, and a tree pseudo-LRU replacement state per set. Lookups complete in one cycle and report hit way plus a victim way for fills. A sequenced flush engine clears every set without stalling the L2 update path. It sits between the L1 request pipeline (lookup) and the L2 response path (fill/invalidate).

Parameters:
NUM_WAYS, 4, ways per set; power of two, 2..8
NUM_SETS, 64, sets; power of two, >=2
TAG_WIDTH, 20, stored tag bits
ADDR_WIDTH, 26, request_addr width; must equal TAG_WIDTH + log2(NUM_SETS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
request_addr  in  ADDR_WIDTH  lookup address; [SET_BITS-1:0] = set, upper bits = tag
access_i  in  1  lookup valid this cycle
cache_hit_o  out  1  hit, valid cycle after access_i
hit_way_o  out  log2(NUM_WAYS)  index of hit way
hit_way_oh_o  out  NUM_WAYS  one-hot hit way
victim_way_o  out  log2(NUM_WAYS)  fill candidate for looked-up set
update_i  in  1  write tag and set valid at update_set_i/update_way_i
invalidate_one_way  in  1  clear valid at update_set_i/update_way_i
update_way_i  in  log2(NUM_WAYS)  target way
update_tag_i  in  TAG_WIDTH  tag to write
update_set_i  in  SET_BITS  target set
flush_i  in  1  start full invalidate sweep
flush_busy_o  out  1  sweep in progress

Behaviour:
- Reset asserted: all valid bits=0, all PLRU bits=0, FSM=IDLE, latched access=0. Outputs: cache_hit_o=0, hit_way_o=0, hit_way_oh_o=0, victim_way_o=0, flush_busy_o=0. Tag contents are undefined after reset.
- Lookup latency is 1 cycle. access_i/request_addr in cycle T gives all response outputs in T+1. With no access_i in T, cache_hit_o=0 and hit_way_oh_o=0 in T+1.
- Hit way w: stored tag == latched request tag && valid[w]. cache_hit_o = |hit_way_oh_o && latched access.
- Write-first forwarding: an update_i or invalidate_one_way in cycle T to the same set as a cycle-T lookup is reflected in the T+1 result.
- victim_way_o selects the lowest-index invalid way of the set if any way is invalid; otherwise it selects the PLRU tree way. Valid only when latched access=1; otherwise 0.
- PLRU: NUM_WAYS-1 bits per set, binary tree, bit=0 points left.
  - On a lookup hit in T+1, the bits on the hit way's path are set to point away from it in the same edge.
  - On update_i, the same is done for update_way_i in update_set_i.
  - If both target the same set in one cycle, the update_i touch is applied last.
- update_i and invalidate_one_way are mutually exclusive; simulation assertion.
- FSM states:
  - IDLE: flush_i -> FLUSH, counter=0.
  - FLUSH: each cycle, clear all valid and PLRU bits of set[counter], then counter++. After set NUM_SETS-1 -> IDLE.
  - A flush takes exactly NUM_SETS cycles; flush_busy_o=1 throughout FLUSH.
- During FLUSH:
  - Lookups return cache_hit_o=0.
  - update_i/invalidate_one_way are still applied. update_i to a set with index >= counter is later cleared by the sweep.
  - flush_i is ignored.
- Reset mid-flush: FSM returns to IDLE immediately, all state cleared.
- Simulation assertion: more than one hit way while latched access=1.

Decomposition:
- Shared defines: L1_NUM_WAYS, L1_NUM_SETS, L1_TAG_WIDTH, L1_SET_INDEX_WIDTH, and the derived way-index width.
- Tag storage: existing sram_1r1w instances, one per way.
- Valid bits and PLRU bits: flops inside this block, because reset and flush must clear them.
- One sub-module, cache_plru_tree (combinational). Inputs: PLRU bits, accessed way. Outputs: next PLRU bits, LRU way. It is instantiated for the lookup-hit touch, the fill touch and victim selection.
- Reuse one_hot_to_index for hit_way_o.

Test Plan:
- Reset, then lookup addr 0x0000040 with access_i=1 -> T+1 cache_hit_o=0, victim_way_o=0.
- update_i set=1 way=2 tag=0x00001, then lookup addr (0x00001<<6)|1 -> cache_hit_o=1, hit_way_o=2, hit_way_oh_o=4'b0100.
- Fill ways 0..3 of set 5, then hit way 0 and way 2 -> victim_way_o=1 (NUM_WAYS=4 tree: root->left, left subtree->way1).
- update_i set=7 way=1 in the same cycle as a lookup to set 7 with the matching tag -> T+1 cache_hit_o=1, hit_way_o=1 (forwarding).
- Fill all sets, pulse flush_i -> flush_busy_o high exactly 64 cycles; lookups during and after return cache_hit_o=0; victim_way_o=0 after.
- Assert reset 10 cycles into a flush -> flush_busy_o=0 the same cycle; all outputs 0; the next lookup misses.
